// File: rtl/tgate_bus_ctrl.sv
// tgate_bus_ctrl
//   Gate-control sequencer for a bank of CMOS transmission gates sharing one
//   bus line. Requesting channels are arbitrated round-robin, and break-before-
//   make dead time is inserted between any deselect and the next select, so
//   at most one gate conducts onto the shared line at any time.
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        synchronous active-low reset
//   req_i          per-channel bus request (level)
//   nctrl_o        NMOS gate controls, 1 = conducting
//   pctrl_o        PMOS gate controls, 0 = conducting (always ~nctrl_o)
//   grant_id_o     index of the current or most recent owner
//   bus_busy_o     a channel is ON
//   dead_active_o  dead time in progress
module tgate_bus_ctrl #(
    parameter  int N_CH     = 4,
    parameter  int DEAD_CYC = 2,
    parameter  int MAX_HOLD = 8,
    localparam int ID_W     = $clog2(N_CH)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [N_CH-1:0] req_i,
    output logic [N_CH-1:0] nctrl_o,
    output logic [N_CH-1:0] pctrl_o,
    output logic [ID_W-1:0] grant_id_o,
    output logic            bus_busy_o,
    output logic            dead_active_o
);

    // +1 keeps the counters at least one bit wide when a limit is 1.
    localparam int DCNT_W = $clog2(DEAD_CYC + 1);
    localparam int HCNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEAD_CYC - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(MAX_HOLD - 1);
    localparam logic [N_CH-1:0]   ONE      = N_CH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEAD = 2'd1,
        S_ON   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_q, last_d;

    logic [N_CH-1:0]   nctrl_q, nctrl_d;
    logic [N_CH-1:0]   pctrl_q;
    logic              busy_q, dead_q;

    // Round-robin pick: first requester strictly after the previous owner,
    // wrapping around, so the previous owner itself has lowest priority.
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    int                arb_idx;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        arb_idx   = 0;
        for (int i = 1; i <= N_CH; i++) begin
            arb_idx = (int'(last_q) + i) % N_CH;
            if (!win_found && req_i[ID_W'(arb_idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(arb_idx);
            end
        end
    end

    logic release_c, preempt_c;
    assign release_c = !req_i[grant_q];
    assign preempt_c = (hcnt_q == HCNT_MAX) && |(req_i & ~(ONE << grant_q));

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    state_d = S_DEAD;
                    dcnt_d  = '0;
                end
            end
            S_DEAD: begin
                if (dcnt_q != DCNT_MAX) begin
                    dcnt_d = dcnt_q + 1'b1;
                end else if (!win_found) begin
                    // Every request dropped during the dead time: nothing to grant.
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ON;
                    grant_d = win_id;
                    last_d  = win_id;
                    hcnt_d  = '0;
                end
            end
            S_ON: begin
                // Release and preempt share the same exit into dead time.
                if (release_c || preempt_c) begin
                    state_d = S_DEAD;
                    dcnt_d  = '0;
                end else if (hcnt_q != HCNT_MAX) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the gates change on the
    // same edge the FSM does.
    always_comb begin
        nctrl_d = '0;
        if (state_d == S_ON) nctrl_d = ONE << grant_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            grant_q <= '0;
            last_q  <= ID_W'(N_CH - 1);
            nctrl_q <= '0;
            pctrl_q <= '1;
            busy_q  <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            nctrl_q <= nctrl_d;
            pctrl_q <= ~nctrl_d;
            busy_q  <= (state_d == S_ON);
            dead_q  <= (state_d == S_DEAD);
        end
    end

    assign nctrl_o       = nctrl_q;
    assign pctrl_o       = pctrl_q;
    assign grant_id_o    = grant_q;
    assign bus_busy_o    = busy_q;
    assign dead_active_o = dead_q;

endmodule

// File: tb/tb_tgate_bus_ctrl.sv
// Directed and random checks for tgate_bus_ctrl with default parameters.
module tb_tgate_bus_ctrl;
    localparam int N_CH     = 4;
    localparam int DEAD_CYC = 2;
    localparam int MAX_HOLD = 8;
    localparam int BOUND    = (N_CH - 1) * (MAX_HOLD + DEAD_CYC) + DEAD_CYC;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] nctrl, pctrl;
    logic [1:0]      grant_id;
    logic            bus_busy, dead_active;

    int total = 0;
    int bad   = 0;

    tgate_bus_ctrl #(.N_CH(N_CH), .DEAD_CYC(DEAD_CYC), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req),
        .nctrl_o(nctrl), .pctrl_o(pctrl), .grant_id_o(grant_id),
        .bus_busy_o(bus_busy), .dead_active_o(dead_active)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Count consecutive sampled cycles with nctrl == pat (bounded).
    task automatic run_len(input logic [N_CH-1:0] pat, output int n);
        n = 0;
        while (nctrl === pat && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        total++; if (nctrl !== 4'b0000) begin bad++; $display("FAIL reset_nctrl got=%b exp=0000", nctrl); end
        total++; if (pctrl !== 4'b1111) begin bad++; $display("FAIL reset_pctrl got=%b exp=1111", pctrl); end
        total++; if (bus_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus_busy); end
        total++; if (dead_active !== 1'b0) begin bad++; $display("FAIL reset_dead got=%b exp=0", dead_active); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        req   = 4'b0000;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        req = 4'b0100;
        tick();
        total++; if (dead_active !== 1'b1 || nctrl !== 4'b0000) begin bad++; $display("FAIL single_e0 got dead=%b nctrl=%b exp dead=1 nctrl=0000", dead_active, nctrl); end
        tick();
        total++; if (dead_active !== 1'b1 || nctrl !== 4'b0000) begin bad++; $display("FAIL single_e1 got dead=%b nctrl=%b exp dead=1 nctrl=0000", dead_active, nctrl); end
        tick();
        total++; if (nctrl !== 4'b0100) begin bad++; $display("FAIL single_nctrl got=%b exp=0100", nctrl); end
        total++; if (pctrl !== 4'b1011) begin bad++; $display("FAIL single_pctrl got=%b exp=1011", pctrl); end
        total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant got=%0d exp=2", grant_id); end
        total++; if (bus_busy !== 1'b1 || dead_active !== 1'b0) begin bad++; $display("FAIL single_flags got busy=%b dead=%b exp busy=1 dead=0", bus_busy, dead_active); end
        req = 4'b0000;
        tick();
        total++; if (nctrl !== 4'b0000 || dead_active !== 1'b1) begin bad++; $display("FAIL single_rel got nctrl=%b dead=%b exp 0000/1", nctrl, dead_active); end
        tick();
        tick();
        total++; if (dead_active !== 1'b0 || bus_busy !== 1'b0) begin bad++; $display("FAIL single_idle got dead=%b busy=%b exp 0/0", dead_active, bus_busy); end
        total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_hold_grant got=%0d exp=2", grant_id); end
    endtask

    task automatic test_rr_preempt;
        int n;
        rst_n = 1'b0;
        req   = 4'b1010;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        run_len(4'b0010, n);
        total++; if (n !== 8) begin bad++; $display("FAIL rr_ch1_on got=%0d exp=8", n); end
        run_len(4'b0000, n);
        total++; if (n !== 2) begin bad++; $display("FAIL rr_gap1 got=%0d exp=2", n); end
        total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL rr_grant3 got=%0d exp=3", grant_id); end
        run_len(4'b1000, n);
        total++; if (n !== 8) begin bad++; $display("FAIL rr_ch3_on got=%0d exp=8", n); end
        run_len(4'b0000, n);
        total++; if (n !== 2) begin bad++; $display("FAIL rr_gap2 got=%0d exp=2", n); end
        total++; if (nctrl !== 4'b0010 || grant_id !== 2'd1) begin bad++; $display("FAIL rr_back_ch1 got nctrl=%b grant=%0d exp 0010/1", nctrl, grant_id); end
        req = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_release_abort;
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        tick();
        total++; if (nctrl !== 4'b0001) begin bad++; $display("FAIL rel_on got=%b exp=0001", nctrl); end
        tick();
        tick();
        req = 4'b0000;
        tick();
        total++; if (nctrl !== 4'b0000 || pctrl !== 4'b1111 || dead_active !== 1'b1) begin bad++; $display("FAIL rel_edge got nctrl=%b pctrl=%b dead=%b exp 0000/1111/1", nctrl, pctrl, dead_active); end
        tick();
        total++; if (dead_active !== 1'b1) begin bad++; $display("FAIL rel_dead2 got=%b exp=1", dead_active); end
        tick();
        total++; if (dead_active !== 1'b0 || bus_busy !== 1'b0) begin bad++; $display("FAIL rel_idle got dead=%b busy=%b exp 0/0", dead_active, bus_busy); end
        req = 4'b0100;
        tick();
        total++; if (dead_active !== 1'b1) begin bad++; $display("FAIL abort_dead got=%b exp=1", dead_active); end
        req = 4'b0000;
        tick();
        total++; if (nctrl !== 4'b0000 || dead_active !== 1'b1) begin bad++; $display("FAIL abort_e1 got nctrl=%b dead=%b exp 0000/1", nctrl, dead_active); end
        tick();
        total++; if (nctrl !== 4'b0000 || dead_active !== 1'b0 || bus_busy !== 1'b0) begin bad++; $display("FAIL abort_idle got nctrl=%b dead=%b busy=%b exp 0000/0/0", nctrl, dead_active, bus_busy); end
        tick();
        total++; if (nctrl !== 4'b0000) begin bad++; $display("FAIL abort_nopulse got=%b exp=0000", nctrl); end
    endtask

    task automatic test_back_to_back;
        // Idle, last owner was 0 from the previous test.
        req = 4'b0001;
        tick();
        tick();
        tick();
        total++; if (nctrl !== 4'b0001) begin bad++; $display("FAIL b2b_on got=%b exp=0001", nctrl); end
        req = 4'b0000;
        tick();
        req = 4'b0001;
        total++; if (nctrl !== 4'b0000) begin bad++; $display("FAIL b2b_rel got=%b exp=0000", nctrl); end
        tick();
        total++; if (nctrl !== 4'b0000 || dead_active !== 1'b1) begin bad++; $display("FAIL b2b_dead got nctrl=%b dead=%b exp 0000/1", nctrl, dead_active); end
        tick();
        total++; if (nctrl !== 4'b0001 || grant_id !== 2'd0) begin bad++; $display("FAIL b2b_regrant got nctrl=%b grant=%0d exp 0001/0", nctrl, grant_id); end
        // Owner releases while a new requester appears in the same cycle.
        req = 4'b0010;
        tick();
        total++; if (nctrl !== 4'b0000) begin bad++; $display("FAIL swap_rel got=%b exp=0000", nctrl); end
        tick();
        total++; if (nctrl !== 4'b0000) begin bad++; $display("FAIL swap_dead got=%b exp=0000", nctrl); end
        tick();
        total++; if (nctrl !== 4'b0010 || grant_id !== 2'd1) begin bad++; $display("FAIL swap_on got nctrl=%b grant=%0d exp 0010/1", nctrl, grant_id); end
        req = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        req = 4'b1000;
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        total++; if (nctrl !== 4'b1000 || bus_busy !== 1'b1) begin bad++; $display("FAIL mid_on got nctrl=%b busy=%b exp 1000/1", nctrl, bus_busy); end
        rst_n = 1'b0;
        tick();
        total++; if (nctrl !== 4'b0000 || pctrl !== 4'b1111) begin bad++; $display("FAIL mid_rst got nctrl=%b pctrl=%b exp 0000/1111", nctrl, pctrl); end
        total++; if (dead_active !== 1'b0 || bus_busy !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL mid_rst_flags got dead=%b busy=%b grant=%0d exp 0/0/0", dead_active, bus_busy, grant_id); end
        rst_n = 1'b1;
        req   = 4'b1001;
        tick();
        total++; if (dead_active !== 1'b1 || nctrl !== 4'b0000) begin bad++; $display("FAIL mid_dead got dead=%b nctrl=%b exp 1/0000", dead_active, nctrl); end
        tick();
        tick();
        total++; if (nctrl !== 4'b0001 || grant_id !== 2'd0) begin bad++; $display("FAIL mid_ch0_first got nctrl=%b grant=%0d exp 0001/0", nctrl, grant_id); end
    endtask

    task automatic test_soak;
        logic [N_CH-1:0] prev;
        int zeros;
        bit seen_on;
        int waitc [N_CH];
        prev    = 4'b0000;
        zeros   = DEAD_CYC;
        seen_on = 1'b0;
        for (int i = 0; i < N_CH; i++) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < N_CH; i++)
                if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
            tick();
            total++; if ((nctrl & (nctrl - 1'b1)) !== 4'b0000) begin bad++; $display("FAIL soak_onehot cyc=%0d got=%b", c, nctrl); end
            total++; if (pctrl !== ~nctrl) begin bad++; $display("FAIL soak_compl cyc=%0d got pctrl=%b exp=%b", c, pctrl, ~nctrl); end
            if (nctrl !== 4'b0000) begin
                if (prev !== 4'b0000) begin
                    total++; if (nctrl !== prev) begin bad++; $display("FAIL soak_switch cyc=%0d got=%b exp=%b", c, nctrl, prev); end
                end else if (seen_on) begin
                    total++; if (zeros < DEAD_CYC) begin bad++; $display("FAIL soak_gap cyc=%0d got=%0d exp>=%0d", c, zeros, DEAD_CYC); end
                end
                seen_on = 1'b1;
                zeros   = 0;
            end else begin
                zeros++;
            end
            prev = nctrl;
            for (int i = 0; i < N_CH; i++) begin
                if (!rst_n || !req[i] || nctrl[i]) waitc[i] = 0;
                else waitc[i]++;
                total++; if (waitc[i] > BOUND) begin bad++; $display("FAIL soak_starve cyc=%0d ch=%0d got=%0d exp<=%0d", c, i, waitc[i], BOUND); end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        test_reset();
        test_single();
        test_rr_preempt();
        test_release_abort();
        test_back_to_back();
        test_reset_mid();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tgate_bus_ctrl.md
# tgate_bus_ctrl

Sequential controller that generates the complementary gate controls for a bank of CMOS transmission gates sharing one bus line. Each channel's `nctrl`/`pctrl` pair drives the `nctrl`/`pctrl` terminals of one CMOS switch. The block sits directly upstream of the switch-level pass-gate stage. It arbitrates round-robin among requesting channels and enforces break-before-make dead time, so that at most one gate ever conducts onto the shared line.

## Interface
- `N_CH`, 4: number of pass-gate channels; must be ≥ 2.
- `DEAD_CYC`, 2: all-off dead-time cycles between any deselect and the next select; must be ≥ 1.
- `MAX_HOLD`, 8: maximum ON cycles for one grant while another channel is requesting; must be ≥ 1.
- Clock/reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `req`  in  N_CH  per-channel bus request, level-sensitive.
- `nctrl`  out  N_CH  NMOS gate control per channel; 1 = conducting.
- `pctrl`  out  N_CH  PMOS gate control per channel; 0 = conducting; always the bitwise complement of `nctrl`.
- `grant_id`  out  $clog2(N_CH)  index of the current or most recent owner.
- `bus_busy`  out  1  high while a channel is ON.
- `dead_active`  out  1  high during dead time.

## Operation
- The FSM has three states.
  - IDLE: all gates off.
  - DEAD: all gates off; `dcnt` counts 0..DEAD_CYC-1.
  - ON: exactly one gate on; `hcnt` counts cycles.
- IDLE → DEAD when `req` is nonzero; `dcnt` is cleared to 0.
- DEAD with `dcnt` < DEAD_CYC-1: `dcnt` increments.
- DEAD with `dcnt` == DEAD_CYC-1: arbitration is performed.
  - `req` == 0: go to IDLE.
  - Otherwise the winner is the first set bit of `req` scanning from `last`+1 upward, modulo N_CH.
  - On a winner: go to ON, set `grant_id` and `last` to the winner, and clear `hcnt`.
- ON → DEAD when `req[grant_id]` == 0 (release).
- ON → DEAD when `hcnt` == MAX_HOLD-1 and `req & ~onehot(grant_id)` is nonzero (preempt).
- ON otherwise: stay in ON; `hcnt` saturates at MAX_HOLD-1.
- The round-robin pointer `last` resets to N_CH-1, so channel 0 has top priority after reset.
- All outputs are registered and decoded from the next state.
  - `nctrl` = onehot(`grant_id`) in ON, 0 otherwise.
  - `pctrl` = ~`nctrl`.
  - `bus_busy` = (state == ON).
  - `dead_active` = (state == DEAD).
- Invariants checked every cycle:
  - `$onehot0(nctrl)`.
  - `pctrl` == ~`nctrl`.
  - Between any two distinct ON periods there are ≥ DEAD_CYC cycles with `nctrl` == 0.
- A re-grant to the same channel after a release still passes through the full dead time.

## Timing
- Reset values (applied at the first rising edge with `rst_n` = 0):
  - `nctrl` = 0, `pctrl` = all ones, `grant_id` = 0.
  - `bus_busy` = 0, `dead_active` = 0.
  - state IDLE, `last` = N_CH-1, `dcnt` = 0, `hcnt` = 0.
- Reset mid-ON or mid-DEAD: gates turn off at the same edge; no dead time is inserted after reset.
- Grant latency from IDLE: `req` sampled at edge k → `dead_active` high for edges k..k+DEAD_CYC-1 → `nctrl` asserted at edge k+DEAD_CYC. With the defaults this is 2 cycles of dead time and the gate is on at the 3rd edge.
- Release latency: `req[grant_id]` sampled low at edge k → `nctrl` = 0 at edge k. The next owner turns on no earlier than edge k+DEAD_CYC.
- Preemption: the owner conducts exactly MAX_HOLD cycles when another channel is waiting for the whole grant.
- A request that drops during DEAD is not granted. If `req` == 0 at arbitration, the block returns to IDLE with no `nctrl` pulse.
- Simultaneous release and preempt conditions give the same single DEAD transition.
- A request arriving in the same cycle as release is seen at arbitration only.
- `grant_id` holds its last value in IDLE and DEAD until the next arbitration.

## Test plan
- Reset: drive `rst_n` = 0 with `req` = 4'b1111 → `nctrl` = 4'b0000, `pctrl` = 4'b1111, `bus_busy` = 0, `dead_active` = 0 after 1 edge.
- Single request: `req` = 4'b0100 from IDLE, sampled at edge 0 → `dead_active` = 1 at edges 0–1, `nctrl` = 4'b0100 and `pctrl` = 4'b1011 at edge 2, `grant_id` = 2.
- Round-robin and preempt:
  - `req` = 4'b1010 held from reset → channel 1 ON for exactly 8 cycles.
  - Then 2 cycles all-off, then channel 3 ON for 8 cycles.
  - Then 2 cycles all-off, then channel 1 again.
- Release and abort:
  - Channel 0 owner drops `req` → `nctrl` = 0 at the same edge; IDLE after 2 dead cycles.
  - Separately, raise `req[2]` then drop it during DEAD → no `nctrl` pulse; return to IDLE.
- Reset mid-operation: assert `rst_n` = 0 while channel 3 is ON at `hcnt` = 4 → `nctrl` = 0 at that edge. After release, `req` = 4'b1001 grants channel 0 first.
- Random soak: 10k cycles of random `req` with random resets → the `$onehot0`, complement and dead-gap invariants hold every cycle, and every continuously requesting channel is granted within (N_CH-1)·(MAX_HOLD+DEAD_CYC)+DEAD_CYC cycles.
